// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter
//   Two-master arbiter and sequencer in front of a single-port, word-addressed
//   data memory (combinational read, synchronous write). Masters are granted
//   round-robin. Byte-masked stores become read-modify-write sequences. Load
//   data is returned registered, together with a one-cycle done pulse.
//   Out-of-range accesses complete with an error and never touch memory.
//
//   Optional build macro: MISALIGN_CHECK_EN
//     defined   - a load, or a store with nonzero be, whose addr[1:0] != 0
//                 completes with err = 1 and no memory access
//     undefined - addr[1:0] is ignored and the containing word is used
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   mX_req/we/addr/      request from master X (0 = core LSU, 1 = debug/DMA).
//   wdata/be             The fields are held stable until mX_done.
//   mX_done/err/rdata    completion pulse, error flag and load data. rdata is
//                        held until the next load completion on that port.
//   mem_read/mem_write   memory strobes
//   mem_address          word-aligned byte address
//   mem_write_data       store data
//   mem_read_data        combinational read data from mem_address
module data_memory_arbiter #(
   parameter int unsigned MEMORY_SIZE = 4096
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_be,
   output logic        m0_done,
   output logic        m0_err,
   output logic [31:0] m0_rdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_be,
   output logic        m1_done,
   output logic        m1_err,
   output logic [31:0] m1_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   input  logic [31:0] mem_read_data
);

   typedef enum logic [2:0] {StIdle, StAccess, StRmwRd, StRmwWr, StDone} state_e;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        port_q, port_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] merged_q, merged_d;
   logic        m0_done_q, m0_done_d, m1_done_q, m1_done_d;
   logic        m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

   // Arbitration and the request fields of the port that would be granted.
   logic        grant_port;
   logic        any_req;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_be;
   logic        out_of_range;
   logic        misaligned;

   // Completion bookkeeping, applied to the port outputs after the FSM.
   logic        fin;
   logic        fin_port;
   logic        fin_err;
   logic        fin_load;
   logic [31:0] fin_rdata;

   always_comb begin
      any_req      = m0_req | m1_req;
      // On a tie the port that was not granted last time wins.
      grant_port   = (m0_req && m1_req) ? ~last_grant_q : m1_req;
      sel_we       = grant_port ? m1_we    : m0_we;
      sel_addr     = grant_port ? m1_addr  : m0_addr;
      sel_wdata    = grant_port ? m1_wdata : m0_wdata;
      sel_be       = grant_port ? m1_be    : m0_be;
      out_of_range = (sel_addr >= MEMORY_SIZE);
   end

`ifdef MISALIGN_CHECK_EN
   // A store with be = 0 performs no access, so its alignment is irrelevant.
   assign misaligned = (sel_addr[1:0] != 2'b00) && (!sel_we || (sel_be != 4'b0000));
`else
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^{sel_addr[1:0], addr_q[1:0]};
   assign misaligned      = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      port_d       = port_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      merged_d     = merged_q;
      fin          = 1'b0;
      fin_port     = port_q;
      fin_err      = 1'b0;
      fin_load     = 1'b0;
      fin_rdata    = 32'h0;

      unique case (state_q)
         StIdle: begin
            if (any_req) begin
               last_grant_d = grant_port;
               port_d       = grant_port;
               we_d         = sel_we;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               be_d         = sel_be;
               fin_port     = grant_port;
               if (out_of_range || misaligned) begin
                  state_d  = StDone;
                  fin      = 1'b1;
                  fin_err  = 1'b1;
                  fin_load = !sel_we;
               end else if (!sel_we || (sel_be == 4'b1111)) begin
                  state_d = StAccess;
               end else if (sel_be == 4'b0000) begin
                  state_d = StDone;
                  fin     = 1'b1;
               end else begin
                  state_d = StRmwRd;
               end
            end
         end
         StAccess: begin
            state_d   = StDone;
            fin       = 1'b1;
            fin_load  = !we_q;
            fin_rdata = mem_read_data;
         end
         StRmwRd: begin
            state_d = StRmwWr;
            for (int i = 0; i < 4; i++) begin
               merged_d[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : mem_read_data[8*i +: 8];
            end
         end
         StRmwWr: begin
            state_d = StDone;
            fin     = 1'b1;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Port outputs change only on that port's completion; done is a pulse,
   // err and rdata hold. Stores never update rdata.
   always_comb begin
      m0_done_d  = 1'b0;
      m1_done_d  = 1'b0;
      m0_err_d   = m0_err_q;
      m1_err_d   = m1_err_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      if (fin) begin
         if (!fin_port) begin
            m0_done_d = 1'b1;
            m0_err_d  = fin_err;
            if (fin_load) begin
               m0_rdata_d = fin_rdata;
            end
         end else begin
            m1_done_d = 1'b1;
            m1_err_d  = fin_err;
            if (fin_load) begin
               m1_rdata_d = fin_rdata;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         last_grant_q <= 1'b1;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         be_q         <= 4'h0;
         merged_q     <= 32'h0;
         m0_done_q    <= 1'b0;
         m1_done_q    <= 1'b0;
         m0_err_q     <= 1'b0;
         m1_err_q     <= 1'b0;
         m0_rdata_q   <= 32'h0;
         m1_rdata_q   <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         port_q       <= port_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         merged_q     <= merged_d;
         m0_done_q    <= m0_done_d;
         m1_done_q    <= m1_done_d;
         m0_err_q     <= m0_err_d;
         m1_err_q     <= m1_err_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
      end
   end

   // Strobes are gated by reset so an abandoned transaction never writes.
   always_comb begin
      mem_read       = !reset && (((state_q == StAccess) && !we_q) || (state_q == StRmwRd));
      mem_write      = !reset && (((state_q == StAccess) && we_q) || (state_q == StRmwWr));
      mem_address    = {addr_q[31:2], 2'b00};
      mem_write_data = (state_q == StRmwWr) ? merged_q : wdata_q;
   end

   assign m0_done  = m0_done_q;
   assign m1_done  = m1_done_q;
   assign m0_err   = m0_err_q;
   assign m1_err   = m1_err_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: directed scenarios followed by
// random single-port transactions, all compared against a transaction-level
// reference model (word array plus per-port rdata and last-grant bookkeeping).
module tb_data_memory_arbiter;

   localparam int unsigned MemSize = 4096;
   localparam int unsigned Words   = MemSize / 4;
`ifdef MISALIGN_CHECK_EN
   localparam bit MisEn = 1'b1;
`else
   localparam bit MisEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_be, m1_be;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_read, mem_write;
   logic [31:0] mem_address, mem_write_data, mem_read_data;

   always #5 clk = ~clk;

   data_memory_arbiter #(.MEMORY_SIZE(MemSize)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_be(m0_be), .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_be(m1_be), .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
   );

   // Memory environment: combinational read, synchronous write.
   logic [31:0] env_mem [Words];
   assign mem_read_data = env_mem[mem_address[11:2]];
   always @(posedge clk) begin
      if (mem_write) env_mem[mem_address[11:2]] <= mem_write_data;
   end

   // Strobe / done monitor, sampled mid-cycle.
   int cyc = 0, rd_cnt = 0, wr_cnt = 0, last_rd_cyc = 0, last_wr_cyc = 0;
   int strobe_in_reset = 0;
   int done_cnt [2] = '{0, 0};
   always @(negedge clk) begin
      cyc++;
      if (mem_read)  begin rd_cnt++; last_rd_cyc = cyc; end
      if (mem_write) begin wr_cnt++; last_wr_cyc = cyc; end
      if (reset && (mem_read || mem_write)) strobe_in_reset++;
      if (m0_done) done_cnt[0]++;
      if (m1_done) done_cnt[1]++;
   end

   // Reference model state.
   logic [31:0] ref_mem [Words];
   logic [31:0] ref_rdata [2];
   int          ref_last_grant;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int p, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be);
      if (p == 0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
      end
   endtask

   // Outcome of one granted transaction, straight from the block's rules.
   task automatic model(input int p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic exp_err, output logic [31:0] exp_rdata,
                        output int exp_lat, output int exp_rd, output int exp_wr);
      logic [31:0] w;
      bit          mis;
      mis = MisEn && (addr[1:0] != 2'b00) && (!we || be != 4'b0000);
      ref_last_grant = p;
      exp_err = 1'b0; exp_rd = 0; exp_wr = 0;
      if (addr >= MemSize || mis) begin
         exp_err = 1'b1; exp_lat = 1;
         if (!we) ref_rdata[p] = 32'h0;
      end else if (!we) begin
         exp_lat = 2; exp_rd = 1;
         ref_rdata[p] = ref_mem[addr / 4];
      end else if (be == 4'hF) begin
         exp_lat = 2; exp_wr = 1;
         ref_mem[addr / 4] = wdata;
      end else if (be == 4'h0) begin
         exp_lat = 1;
      end else begin
         exp_lat = 3; exp_rd = 1; exp_wr = 1;
         w = ref_mem[addr / 4];
         for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
         ref_mem[addr / 4] = w;
      end
      exp_rdata = ref_rdata[p];
   endtask

   // Issue one transaction from an IDLE cycle and check it end to end.
   task automatic do_txn(input int p, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be, input string tag);
      logic        exp_err, got_err;
      logic [31:0] exp_rdata, got_rdata, other_rdata;
      int          exp_lat, exp_rd, exp_wr, lat, rd0, wr0, d_own, d_oth;
      bit          got;
      model(p, we, addr, wdata, be, exp_err, exp_rdata, exp_lat, exp_rd, exp_wr);
      rd0 = rd_cnt; wr0 = wr_cnt; d_own = done_cnt[p]; d_oth = done_cnt[1-p];
      drive(p, 1'b1, we, addr, wdata, be);
      lat = 0; got = 0;
      while (!got && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         got = (p == 0) ? m0_done : m1_done;
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
      got_err     = (p == 0) ? m0_err   : m1_err;
      got_rdata   = (p == 0) ? m0_rdata : m1_rdata;
      other_rdata = (p == 0) ? m1_rdata : m0_rdata;
      drive(p, 1'b0, we, addr, wdata, be);
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_err"}, 32'(got_err), 32'(exp_err));
      check({tag, "_rdata"}, got_rdata, exp_rdata);
      check({tag, "_other_rdata"}, other_rdata, ref_rdata[1-p]);
      @(posedge clk); #1;
      check({tag, "_rd_strobes"}, 32'(rd_cnt - rd0), 32'(exp_rd));
      check({tag, "_wr_strobes"}, 32'(wr_cnt - wr0), 32'(exp_wr));
      check({tag, "_own_dones"}, 32'(done_cnt[p] - d_own), 32'd1);
      check({tag, "_other_dones"}, 32'(done_cnt[1-p] - d_oth), 32'd0);
      if (exp_rd == 1 && exp_wr == 1) begin
         check({tag, "_rmw_order"}, 32'(last_wr_cyc - last_rd_cyc), 32'd1);
      end
   endtask

   initial begin
      int          n, exp_p, wr0, d0, d1, mism;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      for (int i = 0; i < Words; i++) begin
         env_mem[i] = 32'h0;
         ref_mem[i] = 32'h0;
      end
      ref_rdata[0] = 32'h0; ref_rdata[1] = 32'h0; ref_last_grant = 1;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      check("reset_strobes", {30'h0, mem_read, mem_write}, 32'h0);
      check("reset_done_err", {28'h0, m0_done, m0_err, m1_done, m1_err}, 32'h0);
      check("reset_rdata0", m0_rdata, 32'h0);
      check("reset_rdata1", m1_rdata, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Full store then load.
      do_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "st_full");
      do_txn(0, 1'b0, 32'h10, 32'h0, 4'h0, "ld_full");
      check("ld_full_const", m0_rdata, 32'hDEADBEEF);

      // Partial store as read-modify-write.
      do_txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, "st_init20");
      do_txn(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "st_partial");
      do_txn(1, 1'b0, 32'h20, 32'h0, 4'h0, "ld_partial");
      check("ld_partial_const", m1_rdata, 32'h11BB33DD);

      // Out-of-range load, misaligned load, empty store.
      do_txn(0, 1'b0, 32'h1000, 32'h0, 4'h0, "ld_oor");
      check("ld_oor_const", m0_rdata, 32'h0);
      do_txn(1, 1'b0, 32'h22, 32'h0, 4'h0, "ld_misalign");
      check("ld_misalign_const", m1_rdata, MisEn ? 32'h0 : 32'h11BB33DD);
      do_txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, "st_be0");

      // Reset while a partial store sits in its read phase.
      do_txn(1, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, "st_init30");
      wr0 = wr_cnt; d0 = done_cnt[0]; d1 = done_cnt[1];
      drive(1, 1'b1, 1'b1, 32'h30, 32'h12345678, 4'b0011);
      @(posedge clk); #1;
      check("rst_mid_in_rmw_rd", 32'(mem_read), 32'd1);
      reset = 1'b1;
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      #1;
      check("rst_mid_read_gated", 32'(mem_read), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_mid_no_write", 32'(wr_cnt - wr0), 32'd0);
      check("rst_mid_no_done", 32'(done_cnt[0] - d0 + done_cnt[1] - d1), 32'd0);
      check("rst_mid_word", env_mem[32'h30 / 4], 32'hCAFEF00D);
      ref_rdata[0] = 32'h0; ref_rdata[1] = 32'h0; ref_last_grant = 1;
      check("rst_mid_rdata1", m1_rdata, 32'h0);

      // Both masters requesting continuously: grants alternate, m0 first.
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
      drive(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
      exp_p = 1 - ref_last_grant;
      n = 0;
      for (int c = 0; c < 80 && n < 8; c++) begin
         @(posedge clk); #1;
         if (m0_done || m1_done) begin
            check("rr_single_done", 32'(m0_done && m1_done), 32'd0);
            check("rr_port", 32'(m1_done), 32'(exp_p));
            ref_rdata[exp_p] = ref_mem[(exp_p == 0 ? 32'h10 : 32'h20) / 4];
            check("rr_rdata", m1_done ? m1_rdata : m0_rdata, ref_rdata[exp_p]);
            ref_last_grant = exp_p;
            exp_p = 1 - exp_p;
            n++;
         end
      end
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      check("rr_count", 32'(n), 32'd8);
      @(posedge clk); #1;

      // State must be IDLE again: a plain load has its normal latency.
      do_txn(1, 1'b0, 32'h30, 32'h0, 4'h0, "ld_after_rr");

      // Random single-port traffic.
      for (int t = 0; t < 60; t++) begin
         we = 1'($urandom_range(0, 1));
         be = 4'($urandom_range(0, 15));
         if (!we && $urandom_range(0, 7) == 0) begin
            addr = 32'h1000 + 32'($urandom_range(0, 32'h7FFF_0000));
         end else begin
            addr = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
         end
         do_txn(int'($urandom_range(0, 1)), we, addr, $urandom, be, "rand");
      end

      mism = 0;
      for (int i = 0; i < Words; i++) if (env_mem[i] !== ref_mem[i]) mism++;
      check("mem_image", 32'(mism), 32'd0);
      check("strobe_in_reset", 32'(strobe_in_reset), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
